// File: rtl/systolic_input_skewer.sv
// Diagonal-skew feeder for a LANES x LANES systolic array: lane k delayed k cycles,
// framed as array clear, operand stream, then zero-fill drain ending in a frame_done pulse.
module systolic_input_skewer #(
   parameter int LANES        = 5,
   parameter int DW           = 8,
   parameter int DRAIN_CYCLES = 2 * LANES
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [LANES*DW-1:0] vec_in,
   input  logic                vec_valid,
   input  logic                vec_last,
   output logic                vec_ready,
   output logic [LANES*DW-1:0] skew_out,
   output logic                arr_clear,
   output logic                busy,
   output logic                frame_done
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CLEAR  = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;
   localparam logic [1:0] S_DRAIN  = 2'd3;
   localparam int CW = $clog2(DRAIN_CYCLES + 1);

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [CW-1:0] drain_cnt;
   logic          accept;

   assign vec_ready  = (state == S_STREAM);
   assign busy       = (state != S_IDLE);
   assign accept     = vec_valid & vec_ready;
   assign frame_done = (state == S_DRAIN) && (drain_cnt == '0);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (vec_valid) state_nxt = S_CLEAR;
         S_CLEAR:  state_nxt = S_STREAM;
         S_STREAM: if (accept && vec_last) state_nxt = S_DRAIN;
         S_DRAIN:  if (drain_cnt == '0) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // arr_clear is registered so the array sees a glitch-free single-cycle pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         drain_cnt <= '0;
         arr_clear <= 1'b0;
      end else begin
         state     <= state_nxt;
         arr_clear <= (state_nxt == S_CLEAR);
         if (state == S_STREAM && accept && vec_last)
            drain_cnt <= CW'(DRAIN_CYCLES - 1);
         else if (state == S_DRAIN && drain_cnt != '0)
            drain_cnt <= drain_cnt - CW'(1);
      end
   end

   for (genvar k = 1; k <= LANES; k++) begin : g_lane
      logic [DW-1:0] skew_p [0:k-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < k; i++) skew_p[i] <= '0;
         end else if (state == S_CLEAR) begin
            for (int i = 0; i < k; i++) skew_p[i] <= '0;
         end else begin
            skew_p[0] <= accept ? vec_in[k*DW-1 -: DW] : '0;
            for (int i = 1; i < k; i++) skew_p[i] <= skew_p[i-1];
         end
      end

      assign skew_out[k*DW-1 -: DW] = skew_p[k-1];
   end

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Bench for systolic_input_skewer: per-cycle control table plus a timestamped
// scoreboard of accepted vectors that predicts each skewed lane.
module tb_systolic_input_skewer;

   localparam int LANES = 5;
   localparam int DW    = 8;
   localparam int DC    = 2 * LANES;
   localparam int W     = LANES * DW;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] vec_in = '0;
   logic         vec_valid = 1'b0;
   logic         vec_last = 1'b0;
   logic         vec_ready;
   logic [W-1:0] skew_out;
   logic         arr_clear;
   logic         busy;
   logic         frame_done;

   systolic_input_skewer #(.LANES(LANES), .DW(DW), .DRAIN_CYCLES(DC)) dut (
      .clk(clk), .rst_n(rst_n), .vec_in(vec_in), .vec_valid(vec_valid),
      .vec_last(vec_last), .vec_ready(vec_ready), .skew_out(skew_out),
      .arr_clear(arr_clear), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   typedef struct {
      logic         v;
      logic         l;
      logic [W-1:0] d;
      logic         rdy;
      logic         clr;
      logic         bsy;
      logic         done;
   } vec_t;

   typedef struct {
      int           e;
      logic [W-1:0] d;
   } sb_t;

   vec_t tbl[$];
   sb_t  sb[$];
   int   n_vec = 0;
   int   n_fail = 0;
   int   frame_a_end;

   localparam logic [W-1:0] GARB = {LANES{8'hA5}};

   function automatic logic [W-1:0] mk(input int base);
      logic [W-1:0] r;
      for (int k = 1; k <= LANES; k++) r[k*DW-1 -: DW] = 8'(base + k);
      return r;
   endfunction

   function automatic void add(input logic v, input logic l, input logic [W-1:0] d,
                               input logic rdy, input logic clr, input logic bsy,
                               input logic done);
      vec_t r;
      r.v = v; r.l = l; r.d = d; r.rdy = rdy; r.clr = clr; r.bsy = bsy; r.done = done;
      tbl.push_back(r);
   endfunction

   // lane k shows, during the cycle following edge E, the element accepted at edge E-k+1
   function automatic logic [W-1:0] exp_skew();
      logic [W-1:0] r;
      r = '0;
      for (int k = 1; k <= LANES; k++)
         foreach (sb[i])
            if (sb[i].e == edges - k + 1) r[k*DW-1 -: DW] = sb[i].d[k*DW-1 -: DW];
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %h, expected %h", name, edges, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".skew"}, 64'(skew_out), 64'd0);
      chk({tag, ".ready"}, 64'(vec_ready), 64'd0);
      chk({tag, ".clear"}, 64'(arr_clear), 64'd0);
      chk({tag, ".busy"}, 64'(busy), 64'd0);
      chk({tag, ".done"}, 64'(frame_done), 64'd0);
   endtask

   // entered just after a rising edge; leaves just after the next one
   task automatic step(input vec_t r);
      sb_t s;
      vec_valid = r.v;
      vec_last  = r.l;
      vec_in    = r.d;
      @(negedge clk);
      while (sb.size() > 0 && sb[0].e < edges - LANES + 1) void'(sb.pop_front());
      chk("ready", 64'(vec_ready), 64'(r.rdy));
      chk("clear", 64'(arr_clear), 64'(r.clr));
      chk("busy", 64'(busy), 64'(r.bsy));
      chk("done", 64'(frame_done), 64'(r.done));
      chk("skew", 64'(skew_out), 64'(exp_skew()));
      if (r.v && r.rdy) begin
         s.e = edges + 1;
         s.d = r.d;
         sb.push_back(s);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int lo, input int hi);
      for (int i = lo; i < hi; i++) step(tbl[i]);
   endtask

   initial begin
      vec_t r;

      // frame A: single vector lane k = k, valid held high through CLEAR and DRAIN
      add(1, 1, mk(0), 0, 0, 0, 0);
      add(1, 1, GARB,  0, 1, 1, 0);
      add(1, 1, mk(0), 1, 0, 1, 0);
      for (int i = 0; i < DC; i++) add(1, 1'(i % 2), GARB, 0, 0, 1, 1'(i == DC - 1));
      for (int i = 0; i < 3; i++) add(0, 1, GARB, 0, 0, 0, 0);
      frame_a_end = tbl.size();
      // frame B: three back-to-back vectors
      add(1, 0, mk(0),  0, 0, 0, 0);
      add(1, 0, GARB,   0, 1, 1, 0);
      add(1, 0, mk(0),  1, 0, 1, 0);
      add(1, 0, mk(10), 1, 0, 1, 0);
      add(1, 1, mk(20), 1, 0, 1, 0);
      for (int i = 0; i < DC; i++) add(0, 0, GARB, 0, 0, 1, 1'(i == DC - 1));
      for (int i = 0; i < 2; i++) add(0, 0, GARB, 0, 0, 0, 0);
      // frame C: one bubble between two vectors
      add(1, 0, mk(30), 0, 0, 0, 0);
      add(1, 0, GARB,   0, 1, 1, 0);
      add(1, 0, mk(30), 1, 0, 1, 0);
      add(0, 1, GARB,   1, 0, 1, 0);
      add(1, 1, mk(40), 1, 0, 1, 0);
      for (int i = 0; i < DC; i++) add(0, 0, GARB, 0, 0, 1, 1'(i == DC - 1));
      for (int i = 0; i < 2; i++) add(0, 0, GARB, 0, 0, 0, 0);

      // reset held with valid asserted
      rst_n = 1'b0; vec_valid = 1'b1; vec_last = 1'b1; vec_in = GARB;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run(0, tbl.size());

      // mid-frame reset after two accepted vectors
      r = tbl[0]; r.d = mk(50); step(r);
      r = tbl[1]; step(r);
      r = tbl[2]; r.l = 1'b0; r.d = mk(50); step(r);
      r.d = mk(60); step(r);
      chk("pre_reset.skew", 64'(skew_out), 64'(exp_skew()));
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      sb.delete();
      @(posedge clk);
      #1;
      chk_all_zero("reset_hold");
      rst_n = 1'b1;

      run(0, frame_a_end);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
